// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request and regfile write-port bundle
interface regfile_wb_arbiter_if #(
  parameter int n    = 32,
  parameter int r    = 5,
  parameter int NREQ = 3,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*r-1:0]    req_addr;
  logic [NREQ*n-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 we3;
  logic [r-1:0]         wa3;
  logic [n-1:0]         wd3;
  logic [NREQ-1:0]      wr_src;
  logic                 drop_x0;
  logic [NREQ*CNTW-1:0] grant_cnt;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we3, wa3, wd3, wr_src, drop_x0, grant_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we3, wa3, wd3, wr_src, drop_x0, grant_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the regfile write port
module regfile_wb_arbiter #(
  parameter int n    = 32,
  parameter int r    = 5,
  parameter int NREQ = 3,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [r-1:0]    gaddr;
  logic [n-1:0]    gdata;
  logic [CNTW-1:0] cnt [NREQ];
  int              j;

  // Scan from ptr upward (mod NREQ); first valid requester wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    gaddr = '0;
    gdata = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && !reset && bus.req_valid[j]) begin
        found    = 1'b1;
        gidx     = PW'(j);
        grant[j] = 1'b1;
        gaddr    = bus.req_addr[j*r +: r];
        gdata    = bus.req_data[j*n +: n];
      end
    end
  end

  assign bus.req_ready = grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      bus.we3     <= 1'b0;
      bus.wa3     <= '0;
      bus.wd3     <= '0;
      bus.wr_src  <= '0;
      bus.drop_x0 <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      bus.we3     <= 1'b0;
      bus.drop_x0 <= 1'b0;
      if (found) begin
        ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        for (int i = 0; i < NREQ; i++)
          if (grant[i]) cnt[i] <= cnt[i] + 1'b1;
        // Writes to reg 0 still count as accepted but never reach the regfile.
        if (gaddr != '0) begin
          bus.we3    <= 1'b1;
          bus.wa3    <= gaddr;
          bus.wd3    <= gdata;
          bus.wr_src <= grant;
        end else begin
          bus.drop_x0 <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign bus.grant_cnt[g*CNTW +: CNTW] = cnt[g];
  end
endmodule
